updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised synchronous modulo counter, the successor to the fixed 5-bit two-mode counter. It adds configurable width and terminal value, four count modes (up, down, bounce, hold), and a parallel load. It also provides a registered terminal-count pulse and a wrap-event counter. It sits as a general timing/sequencing primitive beside the other counter blocks and is driven directly by control logic or a bench.

## Interface
- WIDTH, 5, bit width of `count` and `load_val`.
- MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL; legal range 1..2**WIDTH-1.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; 0 holds all state.
- mode  input  2  00 up, 01 down, 10 bounce (up/down ping-pong), 11 hold.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value loaded when `load`=1.
- count  output  WIDTH  current count, registered.
- dir  output  1  current direction, 1 = up, 0 = down; registered.
- tc  output  1  terminal-count pulse, registered; high for exactly the cycle after a wrap or turn.
- wrap_cnt  output  8  number of `tc` events, modulo 256.

## Operation
- Priority at each rising edge: rst > load > en. Inputs are sampled only at the edge.
- Reset: count=0, dir=1, tc=0, wrap_cnt=0.
- Load:
  - count = min(load_val, MAX_VAL); out-of-range values clamp to MAX_VAL.
  - dir unchanged, tc=0, wrap_cnt unchanged.
  - `en` is ignored in the same cycle.
- en=0 with no load: count, dir and wrap_cnt hold; tc=0.
- en=1 with no load, per mode:
  - 00 up:
    - count<MAX_VAL: count+1.
    - count==MAX_VAL: 0, tc=1.
    - dir=1.
  - 01 down:
    - count>0: count-1.
    - count==0: MAX_VAL, tc=1.
    - dir=0.
  - 10 bounce, two states UP (dir=1) and DOWN (dir=0):
    - UP, count<MAX_VAL: count+1.
    - UP, count==MAX_VAL: MAX_VAL-1, go to DOWN, tc=1.
    - DOWN, count>0: count-1.
    - DOWN, count==0: 1, go to UP, tc=1.
    - Endpoint values are produced once per sweep, never repeated.
  - 11 hold: count and dir hold, tc=0.
- tc=0 in every cycle where no wrap or turn occurred.
- wrap_cnt increments on the same edge that sets tc=1; 255 wraps to 0.
- Mode change mid-count takes effect at the next enabled edge, starting from the current count.
  - Entering bounce uses the current dir value. After up mode dir=1; after down mode dir=0.
- count > MAX_VAL is unreachable; the clamp on load guarantees it.
- All arithmetic is WIDTH bits, unsigned. Wrap handling is explicit compare-to-endpoint, never natural overflow, so non-power-of-2 MAX_VAL works.

## Timing
- Single clock domain. No combinational path from any input to any output.
- Latency: inputs sampled at edge N appear on outputs after edge N.
- `tc` and the wrapped count value are visible in the same cycle.
- Reset mid-operation (any mode, any count, concurrent load/en) forces reset values at that edge. Counting resumes on the first edge after rst falls.

## Test plan
- Reset/enable:
  - Stimulus: rst=1 for 2 cycles with en=1, load=1, load_val=7; then en=0 for 3 cycles.
  - Response: count=0, dir=1, tc=0, wrap_cnt=0 throughout.
- Up wrap, defaults:
  - Stimulus: mode=00, en=1 for 32 edges from 0.
  - Response: count 1..31 then 0; tc high only with count=0; wrap_cnt=1. After 64 more edges wrap_cnt=3.
- Down with load:
  - Stimulus: load 3, then mode=01, en=1.
  - Response: 3, 2, 1, 0, 31 (tc=1), 30; dir=0.
- Bounce:
  - Stimulus: load 29, mode=10, dir=1.
  - Response: 30, 31, 30 (tc=1, dir=0), 29, ... 1, 0, 1 (tc=1, dir=1).
  - Switching to mode=11 mid-sweep freezes count and dir.
- Non-power-of-2 instance, WIDTH=4, MAX_VAL=9:
  - Stimulus: load 15.
  - Response: count=9, then up mode gives 0 with tc=1.
  - Stimulus: down mode from 0.
  - Response: 9 with tc=1.
- Reset mid-count and priority:
  - Stimulus: at count=17 assert rst with load=1; next edge load=1 with en=1.
  - Response: reset values first. The load wins on the next edge: count=load_val, tc=0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Parametrised up/down/bounce/hold modulo counter with parallel load,
// registered terminal-count pulse and an 8-bit wrap-event counter.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        count enable (0 holds state, clears tc)
//   mode      00 up, 01 down, 10 bounce, 11 hold
//   load      parallel load strobe (wins over en)
//   load_val  value to load, clamped to MAX_VAL
//   count     current count, registered
//   dir       current direction, 1 = up, 0 = down
//   tc        one-cycle pulse with the wrapped/turned count
//   wrap_cnt  number of tc events, modulo 256
module updown_mod_counter #(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic [7:0]       wrap_cnt
);

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_e;

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  dir_e             dir_q;
  dir_e             dir_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic [7:0]       wrap_nxt;
  logic             at_top;
  logic             at_zero;

  assign at_top  = (count == TOP);
  assign at_zero = (count == '0);
  assign dir     = dir_q;

  // Endpoints are detected by explicit compare, so a
  // non-power-of-2 TOP wraps correctly.
  always_comb begin
    count_nxt = count;
    dir_nxt   = dir_q;
    tc_nxt    = 1'b0;
    wrap_nxt  = wrap_cnt;
    if (load) begin
      count_nxt = (load_val > TOP) ? TOP : load_val;
    end else if (en) begin
      unique case (mode)
        2'b00: begin
          dir_nxt = UP;
          if (at_top) begin
            count_nxt = '0;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count + ONE;
          end
        end
        2'b01: begin
          dir_nxt = DOWN;
          if (at_zero) begin
            count_nxt = TOP;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count - ONE;
          end
        end
        2'b10: begin
          // Turn-around steps away from the endpoint so
          // each endpoint appears once per sweep.
          if (dir_q == UP) begin
            if (at_top) begin
              count_nxt = TOP - ONE;
              dir_nxt   = DOWN;
              tc_nxt    = 1'b1;
            end else begin
              count_nxt = count + ONE;
            end
          end else begin
            if (at_zero) begin
              count_nxt = ONE;
              dir_nxt   = UP;
              tc_nxt    = 1'b1;
            end else begin
              count_nxt = count - ONE;
            end
          end
        end
        2'b11: begin
          count_nxt = count;
        end
      endcase
    end
    if (tc_nxt) begin
      wrap_nxt = wrap_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      dir_q    <= UP;
      tc       <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      count    <= count_nxt;
      dir_q    <= dir_nxt;
      tc       <= tc_nxt;
      wrap_cnt <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter: default 5-bit instance
// against a scoreboard model, plus a WIDTH=4 / MAX_VAL=9 instance.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, load;
  logic [1:0] mode;
  logic [4:0] load_val;
  logic [4:0] count;
  logic       dir, tc;
  logic [7:0] wrap_cnt;

  logic       s_rst, s_en, s_load;
  logic [1:0] s_mode;
  logic [3:0] s_load_val;
  logic [3:0] s_count;
  logic       s_dir, s_tc;
  logic [7:0] s_wrap_cnt;

  updown_mod_counter dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .load(load), .load_val(load_val),
    .count(count), .dir(dir), .tc(tc),
    .wrap_cnt(wrap_cnt)
  );

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9)) dut9 (
    .clk(clk), .rst(s_rst), .en(s_en), .mode(s_mode),
    .load(s_load), .load_val(s_load_val),
    .count(s_count), .dir(s_dir), .tc(s_tc),
    .wrap_cnt(s_wrap_cnt)
  );

  typedef struct packed {
    logic [4:0] count;
    logic       dir;
    logic       tc;
    logic [7:0] wrap;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the 5-bit, MAX_VAL=31 instance.
  task automatic model();
    if (rst) begin
      m = '{count: 5'd0, dir: 1'b1, tc: 1'b0, wrap: 8'd0};
    end else if (load) begin
      m.count = load_val;
      m.tc    = 1'b0;
    end else if (!en) begin
      m.tc = 1'b0;
    end else begin
      m.tc = 1'b0;
      case (mode)
        2'b00: begin
          m.dir = 1'b1;
          if (m.count == 5'd31) begin m.count = 5'd0; m.tc = 1'b1; end
          else m.count = m.count + 5'd1;
        end
        2'b01: begin
          m.dir = 1'b0;
          if (m.count == 5'd0) begin m.count = 5'd31; m.tc = 1'b1; end
          else m.count = m.count - 5'd1;
        end
        2'b10: begin
          if (m.dir && m.count == 5'd31) begin
            m.count = 5'd30; m.dir = 1'b0; m.tc = 1'b1;
          end else if (!m.dir && m.count == 5'd0) begin
            m.count = 5'd1; m.dir = 1'b1; m.tc = 1'b1;
          end else if (m.dir) m.count = m.count + 5'd1;
          else m.count = m.count - 5'd1;
        end
        default: ;
      endcase
      if (m.tc) m.wrap = m.wrap + 8'd1;
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input logic l, input logic [1:0] md,
                      input logic [4:0] lv);
    exp_t x;
    rst = r; en = e; load = l; mode = md; load_val = lv;
    model();
    sb.push_back(m);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("sb_count", count, x.count);
    check("sb_dir", dir, x.dir);
    check("sb_tc", tc, x.tc);
    check("sb_wrap", wrap_cnt, x.wrap);
  endtask

  task automatic sstep(input logic r, input logic e,
                       input logic l, input logic [1:0] md,
                       input logic [3:0] lv);
    s_rst = r; s_en = e; s_load = l;
    s_mode = md; s_load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    m = '0;
    s_rst = 1'b0; s_en = 1'b0; s_load = 1'b0;
    s_mode = 2'b00; s_load_val = 4'd0;

    // reset with en/load active, then idle
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 2'b00, 5'd7);
      check("rst_count", count, 0);
      check("rst_dir", dir, 1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
      check("idle_count", count, 0);
      check("idle_wrap", wrap_cnt, 0);
    end

    // up wrap
    for (int i = 1; i <= 32; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'b00, 5'd0);
      check("up_count", count, i % 32);
      check("up_tc", tc, (i == 32));
    end
    check("up_wrap1", wrap_cnt, 1);
    for (int i = 0; i < 64; i++)
      step(1'b0, 1'b1, 1'b0, 2'b00, 5'd0);
    check("up_wrap3", wrap_cnt, 3);

    // down with load, including an en=0 hold after the wrap
    step(1'b0, 1'b0, 1'b1, 2'b01, 5'd3);
    check("ld_count", count, 3);
    check("ld_dir", dir, 1);
    step(1'b0, 1'b1, 1'b0, 2'b01, 5'd0);
    check("dn_2", count, 2);
    step(1'b0, 1'b1, 1'b0, 2'b01, 5'd0);
    step(1'b0, 1'b1, 1'b0, 2'b01, 5'd0);
    check("dn_0", count, 0);
    step(1'b0, 1'b1, 1'b0, 2'b01, 5'd0);
    check("dn_31", count, 31);
    check("dn_tc", tc, 1);
    check("dn_wrap", wrap_cnt, 4);
    step(1'b0, 1'b0, 1'b0, 2'b01, 5'd0);
    check("hold_count", count, 31);
    check("hold_tc", tc, 0);
    step(1'b0, 1'b1, 1'b0, 2'b01, 5'd0);
    check("dn_30", count, 30);
    check("dn_dir", dir, 0);

    // bounce from 29 going up
    step(1'b0, 1'b1, 1'b0, 2'b00, 5'd0);
    step(1'b0, 1'b1, 1'b1, 2'b10, 5'd29);
    check("bl_count", count, 29);
    check("bl_dir", dir, 1);
    step(1'b0, 1'b1, 1'b0, 2'b10, 5'd0);
    step(1'b0, 1'b1, 1'b0, 2'b10, 5'd0);
    check("bo_31", count, 31);
    step(1'b0, 1'b1, 1'b0, 2'b10, 5'd0);
    check("bo_turn_dn", count, 30);
    check("bo_tc_dn", tc, 1);
    check("bo_dir_dn", dir, 0);
    for (int i = 29; i >= 0; i--) begin
      step(1'b0, 1'b1, 1'b0, 2'b10, 5'd0);
      check("bo_sweep", count, i);
    end
    step(1'b0, 1'b1, 1'b0, 2'b10, 5'd0);
    check("bo_turn_up", count, 1);
    check("bo_tc_up", tc, 1);
    check("bo_dir_up", dir, 1);
    step(1'b0, 1'b1, 1'b0, 2'b10, 5'd0);
    step(1'b0, 1'b1, 1'b0, 2'b10, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'b11, 5'd0);
      check("hm_count", count, 3);
      check("hm_dir", dir, 1);
      check("hm_tc", tc, 0);
    end

    // reset mid-count beats load, then load beats en
    step(1'b0, 1'b1, 1'b1, 2'b00, 5'd16);
    step(1'b0, 1'b1, 1'b0, 2'b00, 5'd0);
    check("pr_17", count, 17);
    step(1'b1, 1'b1, 1'b1, 2'b00, 5'd5);
    check("pr_rst_cnt", count, 0);
    check("pr_rst_wrap", wrap_cnt, 0);
    step(1'b0, 1'b1, 1'b1, 2'b00, 5'd12);
    check("pr_load", count, 12);
    check("pr_tc", tc, 0);
    step(1'b0, 1'b1, 1'b0, 2'b00, 5'd0);
    check("pr_resume", count, 13);

    // WIDTH=4, MAX_VAL=9 instance
    sstep(1'b1, 1'b0, 1'b0, 2'b00, 4'd0);
    check("s_rst", s_count, 0);
    sstep(1'b0, 1'b1, 1'b1, 2'b00, 4'd15);
    check("s_clamp", s_count, 9);
    check("s_clamp_tc", s_tc, 0);
    sstep(1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
    check("s_up_wrap", s_count, 0);
    check("s_up_tc", s_tc, 1);
    sstep(1'b0, 1'b1, 1'b0, 2'b01, 4'd0);
    check("s_dn_wrap", s_count, 9);
    check("s_dn_tc", s_tc, 1);
    check("s_wrap", s_wrap_cnt, 2);
    sstep(1'b0, 1'b1, 1'b0, 2'b01, 4'd0);
    check("s_dn_8", s_count, 8);
    check("s_dn_tc0", s_tc, 0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
